// File: rtl/ptw_walker_pkg.sv
// ptw_walker_pkg: shared widths, walker state encodings and PTE field indices
// for the two-level page-table walker (ptw_walker / ptw_pte_decode).
package ptw_walker_pkg;

    localparam int unsigned VPN_WIDTH   = 20;
    localparam int unsigned PPN_WIDTH   = 22;
    localparam int unsigned PTE_WIDTH   = 32;
    localparam int unsigned PADDR_WIDTH = 34;
    localparam int unsigned FLAG_WIDTH  = 8;
    localparam int unsigned LVL_IDX_W   = 10;
    localparam int unsigned PTE_PPN_LSB = 10;

    // PTE flag bit positions
    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_R = 1;
    localparam int unsigned PTE_W = 2;
    localparam int unsigned PTE_X = 3;
    localparam int unsigned PTE_U = 4;
    localparam int unsigned PTE_G = 5;
    localparam int unsigned PTE_A = 6;
    localparam int unsigned PTE_D = 7;

    // Walker state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_L1_REQ  = 3'd1;
    localparam logic [2:0] ST_L1_WAIT = 3'd2;
    localparam logic [2:0] ST_L0_REQ  = 3'd3;
    localparam logic [2:0] ST_L0_WAIT = 3'd4;
    localparam logic [2:0] ST_RESPOND = 3'd5;

endpackage

// File: rtl/ptw_pte_decode.sv
// ptw_pte_decode: combinational PTE classifier.
// Ports: flags (PTE[7:0]), ppn_lo (PTE ppn[9:0]), level (1 = level-1 PTE)
//        -> valid_c, leaf_c, misaligned_c (level-1 leaf with ppn[9:0] != 0),
//           ad_fault_c (A/D violation, only when PTW_AD_CHECK_EN is defined).
module ptw_pte_decode
    import ptw_walker_pkg::*;
(
    input  logic [FLAG_WIDTH-1:0] flags,
    input  logic [LVL_IDX_W-1:0]  ppn_lo,
    input  logic                  level,
    output logic                  valid_c,
    output logic                  leaf_c,
    output logic                  misaligned_c,
    output logic                  ad_fault_c
);

    // W without R is a reserved encoding
    assign valid_c      = flags[PTE_V] && !(!flags[PTE_R] && flags[PTE_W]);
    assign leaf_c       = flags[PTE_R] | flags[PTE_X];
    assign misaligned_c = level && leaf_c && (ppn_lo != '0);

`ifdef PTW_AD_CHECK_EN
    // Software-managed A/D: unset A, or writable page with D clear, faults
    logic flags_unused;
    assign ad_fault_c   = leaf_c && (!flags[PTE_A] || (flags[PTE_W] && !flags[PTE_D]));
    assign flags_unused = ^{flags[PTE_U], flags[PTE_G]};
`else
    logic flags_unused;
    assign ad_fault_c   = 1'b0;
    assign flags_unused = ^{flags[PTE_U], flags[PTE_G], flags[PTE_A], flags[PTE_D]};
`endif

endmodule

// File: rtl/ptw_walker.sv
// ptw_walker: two-level Sv32-style page-table walker, one walk at a time.
// Ports: clk, rst (async active-low); satp_ppn_i; TLB request
//        (ptw_req_valid_i/ready_o/vpn_i); TLB response (ptw_resp_valid_o/
//        ready_i, ppn_o, perm_o, super_o, fault_o); single-outstanding PTE
//        read port (mem_req_valid_o/ready_i/addr_o, mem_resp_valid_i/data_i/err_i).
// Optional: define PTW_AD_CHECK_EN to fault on leaves with A=0 or W=1,D=0.
module ptw_walker
    import ptw_walker_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PPN_WIDTH-1:0]   satp_ppn_i,
    input  logic                   ptw_req_valid_i,
    output logic                   ptw_req_ready_o,
    input  logic [VPN_WIDTH-1:0]   ptw_req_vpn_i,
    output logic                   ptw_resp_valid_o,
    input  logic                   ptw_resp_ready_i,
    output logic [PPN_WIDTH-1:0]   ptw_resp_ppn_o,
    output logic [FLAG_WIDTH-1:0]  ptw_resp_perm_o,
    output logic                   ptw_resp_super_o,
    output logic                   ptw_resp_fault_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                   mem_resp_valid_i,
    input  logic [PTE_WIDTH-1:0]   mem_resp_data_i,
    input  logic                   mem_resp_err_i
);

    logic [2:0]             state_q, state_d;
    logic [LVL_IDX_W-1:0]   vpn_lo_q, vpn_lo_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [PPN_WIDTH-1:0]   resp_ppn_q, resp_ppn_d;
    logic [FLAG_WIDTH-1:0]  resp_perm_q, resp_perm_d;
    logic                   resp_super_q, resp_super_d;
    logic                   resp_fault_q, resp_fault_d;
    logic                   mem_valid_q, mem_valid_d;
    logic [PADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [FLAG_WIDTH-1:0]  pte_flags;
    logic [PPN_WIDTH-1:0]   pte_ppn;
    logic                   pte_valid, pte_leaf, pte_misaligned, pte_ad_fault;
    logic                   rsw_unused;

    assign pte_flags  = mem_resp_data_i[FLAG_WIDTH-1:0];
    assign pte_ppn    = mem_resp_data_i[PTE_WIDTH-1:PTE_PPN_LSB];
    assign rsw_unused = ^mem_resp_data_i[PTE_PPN_LSB-1:FLAG_WIDTH];

    ptw_pte_decode u_decode (
        .flags        (pte_flags),
        .ppn_lo       (pte_ppn[LVL_IDX_W-1:0]),
        .level        (state_q == ST_L1_WAIT),
        .valid_c      (pte_valid),
        .leaf_c       (pte_leaf),
        .misaligned_c (pte_misaligned),
        .ad_fault_c   (pte_ad_fault)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        vpn_lo_d     = vpn_lo_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_ppn_d   = resp_ppn_q;
        resp_perm_d  = resp_perm_q;
        resp_super_d = resp_super_q;
        resp_fault_d = resp_fault_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ptw_req_valid_i && req_ready_q) begin
                    vpn_lo_d    = ptw_req_vpn_i[LVL_IDX_W-1:0];
                    req_ready_d = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {satp_ppn_i, ptw_req_vpn_i[VPN_WIDTH-1:LVL_IDX_W], 2'b00};
                    state_d     = ST_L1_REQ;
                end
            end
            ST_L1_REQ: begin
                if (mem_req_ready_i) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_L1_WAIT;
                end
            end
            ST_L1_WAIT: begin
                if (mem_resp_valid_i) begin
                    // Assume fault; the success and descend paths override it
                    state_d      = ST_RESPOND;
                    resp_valid_d = 1'b1;
                    resp_ppn_d   = '0;
                    resp_perm_d  = mem_resp_err_i ? '0 : pte_flags;
                    resp_super_d = 1'b0;
                    resp_fault_d = 1'b1;
                    if (!mem_resp_err_i && pte_valid && !pte_misaligned) begin
                        if (pte_leaf) begin
                            if (!pte_ad_fault) begin
                                resp_ppn_d   = {pte_ppn[PPN_WIDTH-1:LVL_IDX_W], vpn_lo_q};
                                resp_super_d = 1'b1;
                                resp_fault_d = 1'b0;
                            end
                        end else begin
                            state_d      = ST_L0_REQ;
                            resp_valid_d = 1'b0;
                            mem_valid_d  = 1'b1;
                            mem_addr_d   = {pte_ppn, vpn_lo_q, 2'b00};
                        end
                    end
                end
            end
            ST_L0_REQ: begin
                if (mem_req_ready_i) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_L0_WAIT;
                end
            end
            ST_L0_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d      = ST_RESPOND;
                    resp_valid_d = 1'b1;
                    resp_super_d = 1'b0;
                    if (mem_resp_err_i || !pte_valid || !pte_leaf || pte_ad_fault) begin
                        resp_ppn_d   = '0;
                        resp_perm_d  = mem_resp_err_i ? '0 : pte_flags;
                        resp_fault_d = 1'b1;
                    end else begin
                        resp_ppn_d   = pte_ppn;
                        resp_perm_d  = pte_flags;
                        resp_fault_d = 1'b0;
                    end
                end
            end
            ST_RESPOND: begin
                if (ptw_resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                mem_valid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            vpn_lo_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_ppn_q   <= '0;
            resp_perm_q  <= '0;
            resp_super_q <= 1'b0;
            resp_fault_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            vpn_lo_q     <= vpn_lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_ppn_q   <= resp_ppn_d;
            resp_perm_q  <= resp_perm_d;
            resp_super_q <= resp_super_d;
            resp_fault_q <= resp_fault_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign ptw_req_ready_o  = req_ready_q;
    assign ptw_resp_valid_o = resp_valid_q;
    assign ptw_resp_ppn_o   = resp_ppn_q;
    assign ptw_resp_perm_o  = resp_perm_q;
    assign ptw_resp_super_o = resp_super_q;
    assign ptw_resp_fault_o = resp_fault_q;
    assign mem_req_valid_o  = mem_valid_q;
    assign mem_req_addr_o   = mem_addr_q;

endmodule

// File: tb/tb_ptw_walker.sv
// tb_ptw_walker: directed scoreboard bench for ptw_walker.
module tb_ptw_walker;

    typedef struct packed {
        logic [21:0] ppn;
        logic [7:0]  perm;
        logic        sup;
        logic        fault;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] satp_ppn_i;
    logic        ptw_req_valid_i;
    logic        ptw_req_ready_o;
    logic [19:0] ptw_req_vpn_i;
    logic        ptw_resp_valid_o;
    logic        ptw_resp_ready_i;
    logic [21:0] ptw_resp_ppn_o;
    logic [7:0]  ptw_resp_perm_o;
    logic        ptw_resp_super_o;
    logic        ptw_resp_fault_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [33:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        mem_resp_err_i;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    acc_cyc  = 0;
    int    last_lat = 0;
    resp_t sb[$];

    ptw_walker dut (
        .clk              (clk),
        .rst              (rst),
        .satp_ppn_i       (satp_ppn_i),
        .ptw_req_valid_i  (ptw_req_valid_i),
        .ptw_req_ready_o  (ptw_req_ready_o),
        .ptw_req_vpn_i    (ptw_req_vpn_i),
        .ptw_resp_valid_o (ptw_resp_valid_o),
        .ptw_resp_ready_i (ptw_resp_ready_i),
        .ptw_resp_ppn_o   (ptw_resp_ppn_o),
        .ptw_resp_perm_o  (ptw_resp_perm_o),
        .ptw_resp_super_o (ptw_resp_super_o),
        .ptw_resp_fault_o (ptw_resp_fault_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_req(input logic [21:0] satp, input logic [19:0] vpn,
                             input resp_t e, input bit push, input bit hold);
        int n = 0;
        while (!ptw_req_ready_o && n < 50) begin tick(); n++; end
        chk("req_ready_idle", 64'(ptw_req_ready_o), 64'd1);
        satp_ppn_i      = satp;
        ptw_req_vpn_i   = vpn;
        ptw_req_valid_i = 1'b1;
        if (push) sb.push_back(e);
        tick();
        acc_cyc = cyc;
        if (!hold) ptw_req_valid_i = 1'b0;
        chk("req_ready_busy", 64'(ptw_req_ready_o), 64'd0);
    endtask

    task automatic mem_serve(input logic [33:0] exp_addr, input logic [31:0] pte,
                             input logic err, input int stall);
        int n = 0;
        while (!mem_req_valid_o && n < 50) begin tick(); n++; end
        chk("mem_req_seen", 64'(mem_req_valid_o), 64'd1);
        chk("mem_addr", 64'(mem_req_addr_o), 64'(exp_addr));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("mem_valid_stable", 64'(mem_req_valid_o), 64'd1);
            chk("mem_addr_stable", 64'(mem_req_addr_o), 64'(exp_addr));
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        chk("mem_valid_drop", 64'(mem_req_valid_o), 64'd0);
        chk("req_ready_walk", 64'(ptw_req_ready_o), 64'd0);
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = pte;
        mem_resp_err_i   = err;
        tick();
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i   = 1'b0;
    endtask

    task automatic collect(input int stall);
        int    n = 0;
        resp_t e;
        while (!ptw_resp_valid_o && n < 50) begin tick(); n++; end
        chk("resp_valid", 64'(ptw_resp_valid_o), 64'd1);
        last_lat = cyc - acc_cyc + 1;
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i <= stall; i++) begin
                if (i > 0) tick();
                chk("resp_hold_valid", 64'(ptw_resp_valid_o), 64'd1);
                chk("resp_ppn", 64'(ptw_resp_ppn_o), 64'(e.ppn));
                chk("resp_perm", 64'(ptw_resp_perm_o), 64'(e.perm));
                chk("resp_super", 64'(ptw_resp_super_o), 64'(e.sup));
                chk("resp_fault", 64'(ptw_resp_fault_o), 64'(e.fault));
            end
        end
        ptw_resp_ready_i = 1'b1;
        tick();
        ptw_resp_ready_i = 1'b0;
        ptw_req_valid_i  = 1'b0;
        chk("resp_valid_drop", 64'(ptw_resp_valid_o), 64'd0);
        chk("req_ready_back", 64'(ptw_req_ready_o), 64'd1);
        tick();
        chk("no_reaccept", 64'(mem_req_valid_o), 64'd0);
    endtask

    initial begin
        resp_t e;
        rst              = 1'b0;
        satp_ppn_i       = '0;
        ptw_req_valid_i  = 1'b0;
        ptw_req_vpn_i    = '0;
        ptw_resp_ready_i = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        mem_resp_err_i   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 64'(ptw_req_ready_o), 64'd1);
        chk("rst_resp_valid", 64'(ptw_resp_valid_o), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_req_addr_o), 64'd0);
        chk("rst_resp_ppn", 64'(ptw_resp_ppn_o), 64'd0);
        rst = 1'b1;
        tick();

        // Two-level walk
        e = '{ppn: 22'h12345, perm: 8'hCF, sup: 1'b0, fault: 1'b0};
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h00008001, 1'b0, 0);
        mem_serve(34'h20D14, 32'h048D14CF, 1'b0, 0);
        collect(0);
        chk("lat_two_level", 64'(last_lat), 64'd5);

        // Superpage, response backpressure 4 cycles
        e = '{ppn: 22'h00745, perm: 8'hCF, sup: 1'b1, fault: 1'b0};
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h001000CF, 1'b0, 0);
        chk("super_single_read", 64'(mem_req_valid_o), 64'd0);
        collect(4);
        chk("lat_super", 64'(last_lat), 64'd3);

        // Misaligned superpage, memory request backpressure 3 cycles
        e = '{ppn: 22'h0, perm: 8'hCF, sup: 1'b0, fault: 1'b1};
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h001004CF, 1'b0, 3);
        collect(0);

        // Invalid L1 PTE: no L0 request
        e = '{ppn: 22'h0, perm: 8'h00, sup: 1'b0, fault: 1'b1};
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h00000000, 1'b0, 0);
        chk("no_l0_req", 64'(mem_req_valid_o), 64'd0);
        collect(0);
        chk("lat_l1_fault", 64'(last_lat), 64'd3);

        // Bus error on the L0 read
        e = '{ppn: 22'h0, perm: 8'h00, sup: 1'b0, fault: 1'b1};
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h00008001, 1'b0, 0);
        mem_serve(34'h20D14, 32'h048D14CF, 1'b1, 0);
        collect(0);

        // Request held high through the walk, different satp/vpn
        e = '{ppn: 22'h12345, perm: 8'hCF, sup: 1'b0, fault: 1'b0};
        start_req(22'h00003, 20'hFFC01, e, 1'b1, 1'b1);
        mem_serve(34'h03FFC, 32'h00008001, 1'b0, 0);
        mem_serve(34'h20004, 32'h048D14CF, 1'b0, 0);
        collect(0);

        // Leaf with A=0 at level 0
`ifdef PTW_AD_CHECK_EN
        e = '{ppn: 22'h0, perm: 8'h0F, sup: 1'b0, fault: 1'b1};
`else
        e = '{ppn: 22'h12345, perm: 8'h0F, sup: 1'b0, fault: 1'b0};
`endif
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h00008001, 1'b0, 0);
        mem_serve(34'h20D14, 32'h048D140F, 1'b0, 0);
        collect(0);

        // Reset while waiting for the L0 PTE
        start_req(22'h00010, 20'h12345, e, 1'b0, 1'b0);
        mem_serve(34'h10120, 32'h00008001, 1'b0, 0);
        begin
            int n = 0;
            while (!mem_req_valid_o && n < 50) begin tick(); n++; end
        end
        chk("l0_req_before_rst", 64'(mem_req_valid_o), 64'd1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(ptw_req_ready_o), 64'd1);
        chk("midrst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        chk("midrst_resp_valid", 64'(ptw_resp_valid_o), 64'd0);
        tick();
        rst              = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h048D14CF;
        tick();
        mem_resp_valid_i = 1'b0;
        chk("late_resp_ignored", 64'(ptw_resp_valid_o), 64'd0);
        tick();
        chk("late_resp_idle", 64'(ptw_req_ready_o), 64'd1);
        chk("late_resp_no_mem", 64'(mem_req_valid_o), 64'd0);
        chk("late_resp_no_resp", 64'(ptw_resp_valid_o), 64'd0);

        // Walk after recovery
        e = '{ppn: 22'h12345, perm: 8'hCF, sup: 1'b0, fault: 1'b0};
        start_req(22'h00010, 20'h12345, e, 1'b1, 1'b0);
        mem_serve(34'h10120, 32'h00008001, 1'b0, 0);
        mem_serve(34'h20D14, 32'h048D14CF, 1'b0, 0);
        collect(0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
